muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer for the 32-bit pipelined core; owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and iterates one shift-add or restoring-subtract step per cycle for 32 cycles.
- Raises busy so the hazard logic can stall mfhi/mflo and new muldiv issue.
- Supports mthi/mtlo writes and a pipeline-flush abort.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_seq.sv | 142 ++++++++++++++
 tb/tb_muldiv_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply or restoring-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] p_hi,
  input  logic [XLEN-1:0] p_lo,
  input  logic [XLEN-1:0] operand,
  input  logic            div_mode,
  output logic [XLEN-1:0] nxt_hi,
  output logic [XLEN-1:0] nxt_lo
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, p_hi} + (p_lo[0] ? {1'b0, operand} : '0);
    shifted = {p_hi, p_lo[XLEN-1]};
    // Remainder stays below the divisor, so diff[XLEN] doubles as the borrow.
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      nxt_hi = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      nxt_lo = {p_lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], p_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one step per cycle,
// magnitudes iterated and sign-corrected in a final FIX cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int ITERS = DEF_ITERS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(ITERS);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [XLEN-1:0]    w_hi;
  logic [XLEN-1:0]    w_lo;
  logic [XLEN-1:0]    w_opnd;
  logic [XLEN-1:0]    a_raw;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               signed_op;
  logic               div_op;
  logic [XLEN-1:0]    a_mag;
  logic [XLEN-1:0]    b_mag;
  logic [XLEN-1:0]    step_hi;
  logic [XLEN-1:0]    step_lo;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
    return v[XLEN-1] ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? XLEN'(-v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (2*XLEN)'(-v) : v;
  endfunction

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_mag     = signed_op ? abs_val(a) : a;
  assign b_mag     = signed_op ? abs_val(b) : b;
  assign busy      = (state != ST_IDLE);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .p_hi     (w_hi),
    .p_lo     (w_lo),
    .operand  (w_opnd),
    .div_mode (is_div),
    .nxt_hi   (step_hi),
    .nxt_lo   (step_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      w_hi     <= '0;
      w_lo     <= '0;
      w_opnd   <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          // Capture stage: multiplier/dividend goes in w_lo, the other operand in w_opnd.
          if (start && !abort) begin
            state    <= ST_RUN;
            count    <= '0;
            w_hi     <= '0;
            w_lo     <= div_op ? a_mag : b_mag;
            w_opnd   <= div_op ? b_mag : a_mag;
            a_raw    <= a;
            is_div   <= div_op;
            neg_res  <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem  <= signed_op && a[XLEN-1];
            div_zero <= div_op && (b == '0);
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            w_hi  <= step_hi;
            w_lo  <= step_lo;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(ITERS - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          count <= '0;
          // Sign-correction stage; abort wins over completion.
          if (!abort) begin
            done <= 1'b1;
            if (is_div) begin
              if (div_zero) begin
                lo <= '1;
                hi <= a_raw;
              end else begin
                lo <= cond_neg(w_lo, neg_res);
                hi <= cond_neg(w_hi, neg_rem);
              end
            end else begin
              {hi, lo} <= cond_neg_w({w_hi, w_lo}, neg_res);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, latency, mthi/mtlo, abort, reset.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one operation and follow it to completion; counts busy cycles and done pulses.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int nbusy, output int ndone);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      nbusy++;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(posedge clk); #1;
    if (done) ndone++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_multu();
    int nb, nd;
    run_op(2'b01, 32'hFFFFFFFF, 32'h2, nb, nd);
    n_vec++; if (nb != 33) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 33", nb); end
    n_vec++; if (nd != 1) begin n_err++; $display("FAIL multu_done_pulses got %0d want 1", nd); end
    n_vec++; if (hi !== 32'h1) begin n_err++; $display("FAIL multu_hi got %h want 00000001", hi); end
    n_vec++; if (lo !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_mult();
    int nb, nd;
    run_op(2'b00, 32'hFFFFFFFD, 32'h5, nb, nd);
    n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_vec++; if (lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    run_op(2'b00, 32'h80000000, 32'h80000000, nb, nd);
    n_vec++; if (hi !== 32'h40000000) begin n_err++; $display("FAIL mult_min_hi got %h want 40000000", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL mult_min_lo got %h want 00000000", lo); end
  endtask

  task automatic test_div();
    int nb, nd;
    run_op(2'b10, 32'hFFFFFFF9, 32'h2, nb, nd);
    n_vec++; if (lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi got %h want ffffffff", hi); end
    run_op(2'b11, 32'd100, 32'd7, nb, nd);
    n_vec++; if (lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h want 0000000e", lo); end
    n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h want 00000002", hi); end
  endtask

  task automatic test_div_zero();
    int nb, nd;
    run_op(2'b11, 32'd10, 32'd0, nb, nd);
    n_vec++; if (nb != 33) begin n_err++; $display("FAIL divz_busy_cycles got %0d want 33", nb); end
    n_vec++; if (lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    n_vec++; if (hi !== 32'd10) begin n_err++; $display("FAIL divz_hi got %h want 0000000a", hi); end
  endtask

  task automatic test_div_overflow();
    int nb, nd;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, nb, nd);
    n_vec++; if (lo !== 32'h80000000) begin n_err++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL divovf_hi got %h want 00000000", hi); end
  endtask

  task automatic test_write_with_start();
    int guard;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h55; op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    n_vec++; if (hi !== 32'h55) begin n_err++; $display("FAIL wstart_hi got %h want 00000055", hi); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wstart_busy got %b want 1", busy); end
    @(negedge clk);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h99;
    @(posedge clk); #1;
    lo_we = 1'b0; hi_we = 1'b0;
    n_vec++; if (hi !== 32'h55) begin n_err++; $display("FAIL mthi_busy got %h want 00000055", hi); end
    guard = 0;
    while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL wstart_res_hi got %h want 00000000", hi); end
    n_vec++; if (lo !== 32'd42) begin n_err++; $display("FAIL wstart_res_lo got %h want 0000002a", lo); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_sequence();
    logic saw_done;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h11;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    @(negedge clk); lo_we = 1'b0;
    n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL mthi got %h want 00000011", hi); end
    n_vec++; if (lo !== 32'h22) begin n_err++; $display("FAIL mtlo got %h want 00000022", lo); end
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = (cyc == 5);
      abort = (cyc == 10);
      if (cyc == 10) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL seq_busy_before_abort got %b want 1", busy); end
      end
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", saw_done); end
    n_vec++; if (hi !== 32'h11) begin n_err++; $display("FAIL abort_hi got %h want 00000011", hi); end
    n_vec++; if (lo !== 32'h22) begin n_err++; $display("FAIL abort_lo got %h want 00000022", lo); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy got %b want 0", busy); end
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL async_rst_hi got %h want 00000000", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL async_rst_lo got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_div_overflow();
    test_write_with_start();
    test_abort_idle();
    test_sequence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
